// File: rtl/mcdf_arbiter_rr.sv
// MCDF packet arbiter. On a formatter id request it grants one requesting
// channel. The lowest prio value wins. Ties go round-robin from rr_ptr, or to
// the lowest index when RR_EN=0. The winner's data is then forwarded until
// the formatter signals packet end.
//
// state    | meaning
// ST_IDLE  | waiting for f2a_id_req with at least one channel requesting
// ST_GRANT | one-cycle ack to the winning channel
// ST_XFER  | forwarding the winner's data until f2a_end
module mcdf_arbiter_rr #(
   parameter int CH_NUM = 4,
   parameter int PRIO_W = 2,
   parameter int DATA_W = 32,
   parameter int RR_EN  = 1,
   parameter int ID_W   = $clog2(CH_NUM)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [CH_NUM*PRIO_W-1:0] slv_prios,
   input  logic [CH_NUM-1:0]        slv_reqs,
   input  logic [CH_NUM-1:0]        slv_vals,
   input  logic [CH_NUM*DATA_W-1:0] slv_datas,
   output logic [CH_NUM-1:0]        a2s_acks,
   input  logic                     f2a_id_req,
   input  logic                     f2a_end,
   output logic                     a2f_val,
   output logic [ID_W-1:0]          a2f_id,
   output logic [DATA_W-1:0]        a2f_data,
   output logic                     busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_XFER} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_id;
   logic [PRIO_W-1:0] min_prio;
   logic              win_found;
   logic              arb_go;
   int                scan_idx;

   assign arb_go = (state == ST_IDLE) && f2a_id_req && (|slv_reqs);

   // Arbitration: find the best priority among requesters, then scan from the start point
   always_comb begin
      min_prio  = '1;
      win_id    = '0;
      win_found = 1'b0;
      scan_idx  = 0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (slv_reqs[i] && (slv_prios[i*PRIO_W +: PRIO_W] <= min_prio))
            min_prio = slv_prios[i*PRIO_W +: PRIO_W];
      end
      for (int k = 0; k < CH_NUM; k++) begin
         scan_idx = ((RR_EN != 0) ? int'(rr_ptr) : 0) + k;
         if (scan_idx >= CH_NUM)
            scan_idx = scan_idx - CH_NUM;
         if (!win_found && slv_reqs[scan_idx] &&
             (slv_prios[scan_idx*PRIO_W +: PRIO_W] == min_prio)) begin
            win_found = 1'b1;
            win_id    = ID_W'(scan_idx);
         end
      end
   end

   // State register; reset aborts any packet in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; a request arriving together with f2a_end is not seen until IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (arb_go) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_XFER;
         ST_XFER:  if (f2a_end) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode straight from state so that reset clears them immediately
   always_comb begin
      a2s_acks = '0;
      a2f_val  = 1'b0;
      a2f_data = '0;
      busy     = 1'b0;
      case (state)
         ST_GRANT: begin
            busy = 1'b1;
            for (int i = 0; i < CH_NUM; i++)
               if (a2f_id == ID_W'(i)) a2s_acks[i] = 1'b1;
         end
         ST_XFER: begin
            busy = 1'b1;
            for (int i = 0; i < CH_NUM; i++) begin
               if (a2f_id == ID_W'(i)) begin
                  a2f_val  = slv_vals[i];
                  a2f_data = slv_datas[i*DATA_W +: DATA_W];
               end
            end
         end
         default: ;
      endcase
   end

   // Granted id is captured on the arbitration edge and held until the next grant
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         a2f_id <= '0;
      else if (arb_go)
         a2f_id <= win_id;
   end

   // Round-robin pointer moves past the finished channel, with explicit wrap
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rr_ptr <= '0;
      else if ((RR_EN != 0) && (state == ST_XFER) && f2a_end)
         rr_ptr <= (a2f_id == ID_W'(CH_NUM-1)) ? '0 : a2f_id + 1'b1;
   end

   a_acks_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(a2s_acks));
   a_val_busy:     assert property (@(posedge clk) disable iff (!rstn) a2f_val |-> busy);
   a_single_ack:   assert property (@(posedge clk) disable iff (!rstn) (|a2s_acks) |=> (a2s_acks == '0));

endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// Directed bench for mcdf_arbiter_rr. A round-robin instance and a fixed
// tie-break instance share one stimulus, so tie-break order is compared
// side by side.
module tb_mcdf_arbiter_rr;

   localparam int CH = 4;
   localparam int PW = 2;
   localparam int DW = 32;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rstn;
   logic [CH*PW-1:0]  slv_prios;
   logic [CH-1:0]     slv_reqs;
   logic [CH-1:0]     slv_vals;
   logic [CH*DW-1:0]  slv_datas;
   logic              f2a_id_req;
   logic              f2a_end;

   logic [CH-1:0]     acks_r, acks_f;
   logic              val_r, val_f;
   logic [IW-1:0]     id_r, id_f;
   logic [DW-1:0]     data_r, data_f;
   logic              busy_r, busy_f;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mcdf_arbiter_rr #(.CH_NUM(CH), .PRIO_W(PW), .DATA_W(DW), .RR_EN(1)) dut_rr (
      .clk(clk), .rstn(rstn), .slv_prios(slv_prios), .slv_reqs(slv_reqs),
      .slv_vals(slv_vals), .slv_datas(slv_datas), .a2s_acks(acks_r),
      .f2a_id_req(f2a_id_req), .f2a_end(f2a_end), .a2f_val(val_r),
      .a2f_id(id_r), .a2f_data(data_r), .busy(busy_r));

   mcdf_arbiter_rr #(.CH_NUM(CH), .PRIO_W(PW), .DATA_W(DW), .RR_EN(0)) dut_fx (
      .clk(clk), .rstn(rstn), .slv_prios(slv_prios), .slv_reqs(slv_reqs),
      .slv_vals(slv_vals), .slv_datas(slv_datas), .a2s_acks(acks_f),
      .f2a_id_req(f2a_id_req), .f2a_end(f2a_end), .a2f_val(val_f),
      .a2f_id(id_f), .a2f_data(data_f), .busy(busy_f));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   // One packet of one XFER word, started from an IDLE cycle
   task automatic run_pkt(input string tag, input int exp_r, input int exp_f);
      f2a_id_req = 1'b1;
      smp;
      chk({tag, "_idle_busy"}, 32'(busy_r), 32'd0);
      nxt;
      f2a_id_req = 1'b0;
      smp;
      chk({tag, "_ack_rr"}, 32'(acks_r), 32'(1 << exp_r));
      chk({tag, "_ack_fx"}, 32'(acks_f), 32'(1 << exp_f));
      chk({tag, "_id_rr"}, 32'(id_r), 32'(exp_r));
      chk({tag, "_id_fx"}, 32'(id_f), 32'(exp_f));
      chk({tag, "_busy"}, 32'(busy_r), 32'd1);
      nxt;
      f2a_end = 1'b1;
      smp;
      chk({tag, "_xfer_busy"}, 32'(busy_f), 32'd1);
      chk({tag, "_xfer_ack"}, 32'(acks_r), 32'd0);
      nxt;
      f2a_end = 1'b0;
   endtask

   int          rr_exp[5] = '{0, 1, 2, 3, 0};
   logic        dv[5]     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [31:0] dd[5]     = '{32'hA5A5_0001, 32'hA5A5_FFFF, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rstn       = 1'b0;
      slv_prios  = 8'b00_10_01_11;   // ch3=0 ch2=2 ch1=1 ch0=3
      slv_reqs   = 4'hF;
      slv_vals   = '0;
      slv_datas  = '0;
      f2a_id_req = 1'b0;
      f2a_end    = 1'b0;
      #12;
      chk("rst_acks", 32'(acks_r), 32'd0);
      chk("rst_val",  32'(val_r),  32'd0);
      chk("rst_id",   32'(id_r),   32'd0);
      chk("rst_data", data_r,      32'd0);
      chk("rst_busy", 32'(busy_r), 32'd0);
      nxt;
      rstn = 1'b1;

      // Distinct priorities: ch3 wins in both modes
      run_pkt("prio", 3, 3);

      // Equal priorities, all requesting
      slv_prios = '0;
      for (int p = 0; p < 5; p++)
         run_pkt($sformatf("rr%0d", p), rr_exp[p], 0);

      // Data forwarding from ch2 only
      slv_reqs  = 4'b0100;
      slv_vals  = 4'hF;
      slv_datas = {32'h3333_3333, 32'h0, 32'h2222_2222, 32'h1111_1111};
      f2a_id_req = 1'b1;
      nxt;
      f2a_id_req = 1'b0;
      smp;
      chk("fwd_grant_id", 32'(id_r), 32'd2);
      chk("fwd_grant_val", 32'(val_r), 32'd0);
      chk("fwd_grant_data", data_r, 32'd0);
      nxt;
      for (int c = 0; c < 5; c++) begin
         slv_datas[2*DW +: DW] = dd[c];
         slv_vals[2] = dv[c];
         if (c == 1) begin
            slv_prios = 8'b11_11_11_00;
            slv_reqs  = 4'b0001;
         end
         f2a_end = (c == 4);
         smp;
         chk($sformatf("fwd%0d_val", c), 32'(val_r), 32'(dv[c]));
         chk($sformatf("fwd%0d_data", c), data_r, dd[c]);
         chk($sformatf("fwd%0d_id", c), 32'(id_r), 32'd2);
         chk($sformatf("fwd%0d_data_fx", c), data_f, dd[c]);
         nxt;
      end
      f2a_end   = 1'b0;
      slv_prios = '0;
      slv_reqs  = 4'hF;
      slv_vals  = '0;
      smp;
      chk("fwd_idle_data", data_r, 32'd0);
      chk("fwd_idle_val", 32'(val_r), 32'd0);
      nxt;

      // End and request in the same cycle: grant comes two cycles later
      f2a_id_req = 1'b1;
      nxt;
      f2a_id_req = 1'b0;
      smp;
      chk("sim_ack1_rr", 32'(acks_r), 32'b1000);
      chk("sim_ack1_fx", 32'(acks_f), 32'b0001);
      nxt;
      f2a_end    = 1'b1;
      f2a_id_req = 1'b1;
      smp;
      chk("sim_end_ack", 32'(acks_r), 32'd0);
      nxt;
      f2a_end = 1'b0;
      smp;
      chk("sim_idle_ack", 32'(acks_r), 32'd0);
      chk("sim_idle_busy", 32'(busy_r), 32'd0);
      nxt;
      f2a_id_req = 1'b0;
      smp;
      chk("sim_ack2_rr", 32'(acks_r), 32'b0001);
      chk("sim_ack2_fx", 32'(acks_f), 32'b0001);
      nxt;
      f2a_end = 1'b1;
      nxt;
      f2a_end = 1'b0;

      // Reset in the middle of a packet granted to ch1
      f2a_id_req = 1'b1;
      nxt;
      f2a_id_req = 1'b0;
      smp;
      chk("rstm_ack_rr", 32'(acks_r), 32'b0010);
      nxt;
      nxt;
      nxt;
      slv_vals = 4'hF;
      #1;
      chk("rstm_pre_val", 32'(val_r), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rstm_busy", 32'(busy_r), 32'd0);
      chk("rstm_val", 32'(val_r), 32'd0);
      chk("rstm_acks", 32'(acks_r), 32'd0);
      chk("rstm_busy_fx", 32'(busy_f), 32'd0);
      nxt;
      rstn = 1'b1;
      run_pkt("post_rst", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mcdf_arbiter_rr.md
Name: mcdf_arbiter_rr

Overview:
- Parametrised packet arbiter for the MCDF datapath. Sits between CH_NUM channel slave FIFOs and the formatter.
- On a formatter ID request, it grants one requesting channel by programmable priority, with round-robin tie-break among equal priorities.
- It then forwards that channel's data to the formatter until the formatter signals packet end.
- Generalises the fixed 3-channel arbiter: channel count, priority width, data width and tie-break mode are all parameters.

Parameters:
- CH_NUM, 4, number of channel slaves (2..16).
- PRIO_W, 2, priority field width per channel; value 0 is highest priority.
- DATA_W, 32, data width.
- RR_EN, 1, 1 = round-robin tie-break; 0 = fixed tie-break, lowest index wins.
- ID_W, $clog2(CH_NUM), channel id width (derived; do not override).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- slv_prios  in  CH_NUM*PRIO_W  per-channel priority; channel i occupies bits [i*PRIO_W +: PRIO_W]
- slv_reqs  in  CH_NUM  per-channel packet-ready request
- slv_vals  in  CH_NUM  per-channel data valid
- slv_datas  in  CH_NUM*DATA_W  per-channel data; channel i occupies [i*DATA_W +: DATA_W]
- a2s_acks  out  CH_NUM  one-cycle grant acknowledge to the winning slave
- f2a_id_req  in  1  formatter requests the next packet source
- f2a_end  in  1  formatter pulse marking the last word of the current packet
- a2f_val  out  1  forwarded data valid
- a2f_id  out  ID_W  granted channel id
- a2f_data  out  DATA_W  forwarded data
- busy  out  1  high while a packet is granted

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset state: a2s_acks=0, a2f_val=0, a2f_id=0, a2f_data=0, busy=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-packet aborts the packet immediately. No ack or valid is issued after rstn falls.
- FSM states: IDLE, GRANT, XFER.
- IDLE:
  - If f2a_id_req=1 and |slv_reqs, arbitrate combinationally and go to GRANT at the next edge.
  - a2f_id and the rr_ptr snapshot are registered at that edge.
  - Otherwise stay in IDLE.
- Arbitration (in IDLE, on the arbitration cycle only):
  - Candidates are the channels with slv_reqs=1.
  - Winner has the minimum slv_prios value among candidates.
  - Ties with RR_EN=1: first tied channel scanning upward from rr_ptr, wrapping CH_NUM-1 -> 0.
  - Ties with RR_EN=0: lowest index wins.
  - slv_prios is sampled only on the arbitration cycle. Changes during GRANT/XFER have no effect on the current packet.
- GRANT:
  - Lasts exactly one cycle.
  - a2s_acks[a2f_id]=1; all other ack bits 0.
  - busy=1. Next state is XFER.
- XFER:
  - busy=1.
  - a2f_val = slv_vals[a2f_id]; a2f_data = slv_datas[a2f_id]. Both are combinational muxes, zero latency.
  - On f2a_end=1: go to IDLE.
    - RR_EN=1: rr_ptr <= (a2f_id+1) mod CH_NUM, with explicit wrap (CH_NUM need not be a power of 2).
    - RR_EN=0: rr_ptr unchanged.
- Outside XFER: a2f_val=0 and a2f_data=0. a2f_id holds its last granted value.
- Latency: f2a_id_req sampled high in IDLE -> ack and busy one cycle later -> data forwarded from the following cycle.
- Minimum gap: f2a_end and f2a_id_req high in the same cycle:
  - The end is honoured; the request is ignored that cycle.
  - Re-arbitration occurs in the first IDLE cycle, giving at least one IDLE cycle between packets.
- Ignored events:
  - f2a_end outside XFER is ignored.
  - f2a_id_req outside IDLE is ignored.
  - f2a_id_req with no request stays in IDLE with no ack.
- A requester dropping slv_reqs after arbitration does not cancel the grant; the packet proceeds until f2a_end.
- Assertions:
  - a2s_acks is onehot0.
  - a2f_val implies busy.
  - At most one ack per grant.

Test Plan:
- Fixed priority: CH_NUM=4, prios {ch0:3, ch1:1, ch2:2, ch3:0}, all reqs=1, f2a_id_req pulse -> ack on ch3 only, a2f_id=3, busy=1 one cycle after the request.
- Round-robin: RR_EN=1, all prios=0, all reqs held high, 5 packets each ended by f2a_end -> grant order 0,1,2,3,0, with one IDLE cycle between packets.
- Fixed tie-break: same stimulus with RR_EN=0 -> grant order 0,0,0,0,0.
- Data forward: grant ch2, drive slv_datas ch2 = 0xA5A5_0001..0004 with slv_vals toggling 1,0,1,1,1 -> a2f_data/a2f_val match ch2 cycle-for-cycle; other channels' data never appears.
- Simultaneous and boundary events:
  - f2a_end and f2a_id_req in the same cycle -> no ack that cycle; ack follows 2 cycles later.
  - Priority change during XFER does not alter a2f_id.
- Reset mid-packet: rstn low during XFER at word 2 -> same-timestep busy=0, a2f_val=0, a2s_acks=0.
  - After release, rr_ptr=0: with all prios equal and all reqs high, the next grant goes to ch0.
